systolic_array_ctrl: RTL

- Sequencer for a ROWS x COLS weight-stationary PE array (16-bit Q6.10 datapath, product bits [25:10]).
- On start, the block runs three phases in order:
  - preloads weights from weight SRAM via weight_en;
  - streams activation vectors from ifmap SRAM with per-row skew;
  - tracks partial-sum drain and issues ofmap writes.
- Sits between the array top level and the on-chip buffers. It never touches data, only enables and addresses.

---
 rtl/systolic_array_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/systolic_array_ctrl.sv
// Sequencer for a weight-stationary ROWS x COLS PE array: weight preload, skewed activation stream, ofmap drain.
// Optional cycle counter output perf_cycles is built when SYSTOLIC_ARRAY_CTRL_PERF_EN is defined.
module systolic_array_ctrl #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int AW   = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AW-1:0]   num_vec,
  input  logic [AW-1:0]   w_base,
  input  logic [AW-1:0]   a_base,
  input  logic [AW-1:0]   o_base,
  output logic            w_rd_en,
  output logic [AW-1:0]   w_rd_addr,
  output logic            weight_en,
  output logic            a_rd_en,
  output logic [AW-1:0]   a_rd_addr,
  output logic [ROWS-1:0] act_valid,
  output logic [COLS-1:0] col_valid,
  output logic            o_wr_en,
  output logic [AW-1:0]   o_wr_addr,
  output logic            busy,
  output logic            done
`ifdef SYSTOLIC_ARRAY_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_cycles
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

  localparam logic [AW-1:0] ONE_C  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] ROWS_C = ROWS[AW-1:0];

  state_t          state_r, state_n_s;
  logic [AW-1:0]   cnt_r, cnt_n_s;
  logic [AW-1:0]   wr_cnt_r;
  logic [AW-1:0]   num_vec_r, w_base_r, a_base_r, o_base_r;
  logic            accept_s;
  logic            w_rd_en_r, w_rd_en_n_s;
  logic [AW-1:0]   w_rd_addr_r, w_rd_addr_n_s;
  logic            a_rd_en_r, a_rd_en_n_s;
  logic [AW-1:0]   a_rd_addr_r, a_rd_addr_n_s;
  logic            weight_en_r;
  logic [ROWS-1:0] act_valid_r;
  logic [COLS-1:0] col_valid_r;
  logic            o_wr_en_r;
  logic [AW-1:0]   o_wr_addr_r;
  logic            busy_r, done_r, done_n_s;

  // Next-state and next-cycle strobe/address values; outputs are the registered copies.
  always_comb begin
    state_n_s     = state_r;
    cnt_n_s       = cnt_r;
    accept_s      = 1'b0;
    w_rd_en_n_s   = 1'b0;
    w_rd_addr_n_s = '0;
    a_rd_en_n_s   = 1'b0;
    a_rd_addr_n_s = '0;
    done_n_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          cnt_n_s  = '0;
          if (num_vec != '0) begin
            state_n_s     = LOAD_W;
            w_rd_en_n_s   = 1'b1;
            w_rd_addr_n_s = w_base;
          end else begin
            state_n_s = DONE;
            done_n_s  = 1'b1;
          end
        end else begin
          state_n_s = IDLE;
        end
      end
      LOAD_W: begin
        if (cnt_r == ROWS_C) begin
          state_n_s     = STREAM;
          cnt_n_s       = '0;
          a_rd_en_n_s   = 1'b1;
          a_rd_addr_n_s = a_base_r;
        end else if (cnt_r < ROWS_C - ONE_C) begin
          cnt_n_s       = cnt_r + ONE_C;
          w_rd_en_n_s   = 1'b1;
          w_rd_addr_n_s = w_base_r + cnt_r + ONE_C;
        end else begin
          cnt_n_s = cnt_r + ONE_C;
        end
      end
      STREAM: begin
        if (cnt_r + ONE_C < num_vec_r) begin
          cnt_n_s       = cnt_r + ONE_C;
          a_rd_en_n_s   = 1'b1;
          a_rd_addr_n_s = a_base_r + cnt_r + ONE_C;
        end else begin
          state_n_s = DRAIN;
        end
      end
      DRAIN: begin
        if (wr_cnt_r == num_vec_r) begin
          state_n_s = DONE;
          done_n_s  = 1'b1;
        end else begin
          state_n_s = DRAIN;
        end
      end
      DONE:    state_n_s = IDLE;
      default: state_n_s = IDLE;
    endcase
  end

  // State, configuration latch, strobe registers and the skew/deskew pipelines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      wr_cnt_r    <= '0;
      num_vec_r   <= '0;
      w_base_r    <= '0;
      a_base_r    <= '0;
      o_base_r    <= '0;
      w_rd_en_r   <= 1'b0;
      w_rd_addr_r <= '0;
      a_rd_en_r   <= 1'b0;
      a_rd_addr_r <= '0;
      weight_en_r <= 1'b0;
      act_valid_r <= '0;
      col_valid_r <= '0;
      o_wr_en_r   <= 1'b0;
      o_wr_addr_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      cnt_r       <= cnt_n_s;
      w_rd_en_r   <= w_rd_en_n_s;
      w_rd_addr_r <= w_rd_addr_n_s;
      a_rd_en_r   <= a_rd_en_n_s;
      a_rd_addr_r <= a_rd_addr_n_s;
      // Weight lands one cycle after its read; activations and partial sums ripple one stage per cycle.
      weight_en_r <= w_rd_en_r;
      act_valid_r <= {act_valid_r[ROWS-2:0], a_rd_en_r};
      col_valid_r <= {col_valid_r[COLS-2:0], act_valid_r[ROWS-1]};
      o_wr_en_r   <= col_valid_r[COLS-1];
      busy_r      <= (state_n_s != IDLE);
      done_r      <= done_n_s;
      if (col_valid_r[COLS-1]) begin
        o_wr_addr_r <= o_base_r + wr_cnt_r;
        wr_cnt_r    <= wr_cnt_r + ONE_C;
      end else begin
        o_wr_addr_r <= '0;
      end
      if (accept_s) begin
        num_vec_r <= num_vec;
        w_base_r  <= w_base;
        a_base_r  <= a_base;
        o_base_r  <= o_base;
        wr_cnt_r  <= '0;
      end
    end
  end

  assign w_rd_en   = w_rd_en_r;
  assign w_rd_addr = w_rd_addr_r;
  assign weight_en = weight_en_r;
  assign a_rd_en   = a_rd_en_r;
  assign a_rd_addr = a_rd_addr_r;
  assign act_valid = act_valid_r;
  assign col_valid = col_valid_r;
  assign o_wr_en   = o_wr_en_r;
  assign o_wr_addr = o_wr_addr_r;
  assign busy      = busy_r;
  assign done      = done_r;

`ifdef SYSTOLIC_ARRAY_CTRL_PERF_EN
  logic [31:0] perf_cnt_r, perf_cnt_n_s, perf_cycles_r;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Running count of busy cycles including the one about to start.
  always_comb begin
    perf_cnt_n_s = perf_cnt_r;
    if (accept_s) begin
      perf_cnt_n_s = 32'd1;
    end else if (state_n_s != IDLE) begin
      perf_cnt_n_s = sat_inc(perf_cnt_r);
    end else begin
      perf_cnt_n_s = perf_cnt_r;
    end
  end

  // Counter plus the published total, refreshed as the DONE cycle begins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cnt_r    <= 32'd0;
      perf_cycles_r <= 32'd0;
    end else begin
      perf_cnt_r <= perf_cnt_n_s;
      if (state_n_s == DONE) begin
        perf_cycles_r <= perf_cnt_n_s;
      end
    end
  end

  assign perf_cycles = perf_cycles_r;
`endif

endmodule
